// File: rtl/fsk_pkg.sv
// fsk_pkg: shared FSK carrier types and defaults
package fsk_pkg;
  localparam int FSK_CNT_W        = 9;
  localparam int FSK_NUM_TONES    = 4;
  localparam int FSK_DEFAULT_HALF = 256;
  typedef logic [FSK_CNT_W-1:0] half_t;
  typedef logic [$clog2(FSK_NUM_TONES)-1:0] tone_t;
  typedef enum logic {RUN, HOLD} mode_t;
endpackage

// File: rtl/tone_table.sv
// tone_table: validated half-period register file with async read port
module tone_table
  import fsk_pkg::*;
#(
  parameter int CNT_W        = FSK_CNT_W,
  parameter int NUM_TONES    = FSK_NUM_TONES,
  parameter int SEL_W        = $clog2(NUM_TONES),
  parameter int DEFAULT_HALF = FSK_DEFAULT_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] rd,
  output logic             cfg_err
);
  localparam logic [SEL_W:0] NT  = NUM_TONES[SEL_W:0];
  localparam logic [CNT_W-1:0] DEF = DEFAULT_HALF[CNT_W-1:0];
  logic [CNT_W-1:0] tbl [NUM_TONES];
  logic ok;
  assign ok = cfg_we && ({1'b0, cfg_idx} < NT) && |cfg_half;
  // Reads see the pre-edge contents, so a same-cycle reload gets the old value
  assign rd = ({1'b0, sel} < NT) ? tbl[sel] : DEF;
  // Accept only in-range, nonzero writes; flag everything else for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TONES; i++) tbl[i] <= DEF;
      cfg_err <= 1'b0;
    end else begin
      if (ok) tbl[cfg_idx] <= cfg_half;
      cfg_err <= cfg_we && !ok;
    end
  end
endmodule

// File: rtl/fsk_tone_divider.sv
// fsk_tone_divider: phase-continuous multi-tone 50% square-wave carrier divider
module fsk_tone_divider
  import fsk_pkg::*;
#(
  parameter int CNT_W        = FSK_CNT_W,
  parameter int NUM_TONES    = FSK_NUM_TONES,
  parameter int SEL_W        = $clog2(NUM_TONES),
  parameter int DEFAULT_HALF = FSK_DEFAULT_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [SEL_W-1:0] tone_sel,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             out,
  output logic             tick,
  output logic [SEL_W-1:0] active_tone,
  output logic             cfg_err
);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DEFAULT_HALF - 1);
  mode_t mode;
  logic [CNT_W-1:0] cnt, cnt_n, rd;
  logic out_n, tick_n, boundary, reload;
  logic [SEL_W-1:0] tone_n;
  tone_table #(
    .CNT_W(CNT_W), .NUM_TONES(NUM_TONES), .SEL_W(SEL_W), .DEFAULT_HALF(DEFAULT_HALF)
  ) u_table (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_half(cfg_half),
    .sel(tone_sel), .rd(rd), .cfg_err(cfg_err)
  );
  // Mode follows en in the same cycle so a low en freezes that very edge
  always_comb mode = en ? RUN : HOLD;
  // Next state: restart beats a boundary; both reload from the selected tone
  always_comb begin
    boundary = (mode == RUN) && (cnt == '0);
    reload   = restart || boundary;
    cnt_n    = reload ? rd - 1'b1 : (mode == RUN) ? cnt - 1'b1 : cnt;
    tone_n   = reload ? tone_sel : active_tone;
    out_n    = restart ? 1'b0 : boundary ? ~out : out;
    tick_n   = !restart && boundary;
  end
  // Registered outputs and counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= CNT_RST;
      out         <= 1'b0;
      tick        <= 1'b0;
      active_tone <= '0;
    end else begin
      cnt         <= cnt_n;
      out         <= out_n;
      tick        <= tick_n;
      active_tone <= tone_n;
    end
  end
endmodule

// File: tb/tb_fsk_tone_divider.sv
// tb_fsk_tone_divider: directed self-checking bench for the FSK tone divider
module tb_fsk_tone_divider;
  logic clk = 1'b0;
  logic rst, en, restart, cfg_we;
  logic [1:0] tone_sel, cfg_idx;
  logic [8:0] cfg_half;
  logic out, tick, cfg_err, out3, tick3, cfg_err3;
  logic [1:0] active_tone, active_tone3;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fsk_tone_divider dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .tone_sel(tone_sel),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_half(cfg_half),
    .out(out), .tick(tick), .active_tone(active_tone), .cfg_err(cfg_err)
  );

  fsk_tone_divider #(.NUM_TONES(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .tone_sel(tone_sel),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_half(cfg_half),
    .out(out3), .tick(tick3), .active_tone(active_tone3), .cfg_err(cfg_err3)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_to_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 1000);
  endtask

  task automatic write_cfg(input logic [1:0] idx, input logic [8:0] half);
    cfg_we = 1'b1; cfg_idx = idx; cfg_half = half;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_restart(input logic [1:0] sel);
    tone_sel = sel; restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; restart = 1'b0; cfg_we = 1'b0;
    tone_sel = 2'd0; cfg_idx = 2'd0; cfg_half = 9'd0;
    #3;
    tests++;
    if ({out, tick, cfg_err, active_tone} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got out=%b tick=%b err=%b tone=%0d, want all 0", out, tick, cfg_err, active_tone);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
  endtask

  task automatic test_default();
    int n;
    count_to_tick(n);
    tests++;
    if (n !== 256 || out !== 1'b1) begin
      fails++;
      $display("FAIL default_first_tick: got %0d cycles out=%b, want 256 out=1", n, out);
    end
    count_to_tick(n);
    tests++;
    if (n !== 256 || out !== 1'b0) begin
      fails++;
      $display("FAIL default_high_half: got %0d cycles out=%b, want 256 out=0", n, out);
    end
    tests++;
    if (active_tone !== 2'd0) begin
      fails++;
      $display("FAIL default_tone: got %0d, want 0", active_tone);
    end
  endtask

  task automatic test_tone_switch();
    int n;
    write_cfg(2'd1, 9'd3);
    write_cfg(2'd2, 9'd5);
    do_restart(2'd1);
    tests++;
    if (out !== 1'b0 || tick !== 1'b0 || active_tone !== 2'd1) begin
      fails++;
      $display("FAIL switch_restart: got out=%b tick=%b tone=%0d, want 0 0 1", out, tick, active_tone);
    end
    count_to_tick(n);
    tests++;
    if (n !== 3 || out !== 1'b1) begin
      fails++;
      $display("FAIL switch_h3_first: got %0d out=%b, want 3 out=1", n, out);
    end
    count_to_tick(n);
    tests++;
    if (n !== 3 || out !== 1'b0) begin
      fails++;
      $display("FAIL switch_h3_second: got %0d out=%b, want 3 out=0", n, out);
    end
    step();
    tone_sel = 2'd2;
    count_to_tick(n);
    tests++;
    if (n + 1 !== 3 || out !== 1'b1 || active_tone !== 2'd2) begin
      fails++;
      $display("FAIL switch_mid_half: got %0d out=%b tone=%0d, want 3 out=1 tone=2", n + 1, out, active_tone);
    end
    count_to_tick(n);
    tests++;
    if (n !== 5 || out !== 1'b0) begin
      fails++;
      $display("FAIL switch_h5_first: got %0d out=%b, want 5 out=0", n, out);
    end
    count_to_tick(n);
    tests++;
    if (n !== 5 || out !== 1'b1) begin
      fails++;
      $display("FAIL switch_h5_second: got %0d out=%b, want 5 out=1", n, out);
    end
  endtask

  task automatic test_fast();
    write_cfg(2'd0, 9'd1);
    do_restart(2'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (tick !== 1'b1 || out !== ((i % 2) == 0)) begin
        fails++;
        $display("FAIL fast_toggle[%0d]: got tick=%b out=%b, want tick=1 out=%b", i, tick, out, (i % 2) == 0);
      end
    end
  endtask

  task automatic test_hold();
    int n;
    int bad = 0;
    do_restart(2'd2);
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick !== 1'b0 || out !== 1'b0 || active_tone !== 2'd2) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_frozen: got %0d bad cycles, want 0", bad);
    end
    en = 1'b1;
    count_to_tick(n);
    tests++;
    if (n !== 3 || out !== 1'b1) begin
      fails++;
      $display("FAIL hold_resume: got %0d out=%b, want 3 out=1", n, out);
    end
  endtask

  task automatic test_cfg_err();
    int n;
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_half = 9'd0;
    step();
    cfg_we = 1'b0;
    tests++;
    if (cfg_err !== 1'b1) begin
      fails++;
      $display("FAIL err_zero_pulse: got %b, want 1", cfg_err);
    end
    step();
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL err_zero_clear: got %b, want 0", cfg_err);
    end
    do_restart(2'd3);
    count_to_tick(n);
    tests++;
    if (n !== 256) begin
      fails++;
      $display("FAIL err_table_kept: got %0d, want 256", n);
    end
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_half = 9'd5;
    step();
    cfg_we = 1'b0;
    tests++;
    if (cfg_err !== 1'b0 || cfg_err3 !== 1'b1) begin
      fails++;
      $display("FAIL err_idx_range: got err4=%b err3=%b, want 0 1", cfg_err, cfg_err3);
    end
    step();
    tests++;
    if (cfg_err3 !== 1'b0) begin
      fails++;
      $display("FAIL err_idx_clear: got %b, want 0", cfg_err3);
    end
  endtask

  task automatic test_collision();
    int n;
    write_cfg(2'd1, 9'd4);
    do_restart(2'd1);
    step();
    step();
    step();
    restart = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_half = 9'd7;
    step();
    restart = 1'b0; cfg_we = 1'b0;
    tests++;
    if (out !== 1'b0 || tick !== 1'b0) begin
      fails++;
      $display("FAIL collide_restart: got out=%b tick=%b, want 0 0", out, tick);
    end
    count_to_tick(n);
    tests++;
    if (n !== 4 || out !== 1'b1) begin
      fails++;
      $display("FAIL collide_old_half: got %0d out=%b, want 4 out=1", n, out);
    end
    count_to_tick(n);
    tests++;
    if (n !== 7 || out !== 1'b0) begin
      fails++;
      $display("FAIL collide_new_half: got %0d out=%b, want 7 out=0", n, out);
    end
    count_to_tick(n);
    step();
    #2 rst = 1'b0;
    #1;
    tests++;
    if (out !== 1'b0 || tick !== 1'b0 || active_tone !== 2'd0) begin
      fails++;
      $display("FAIL async_reset: got out=%b tick=%b tone=%0d, want 0 0 0", out, tick, active_tone);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_tone_switch();
    test_fast();
    test_hold();
    test_cfg_err();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fsk_tone_divider.md
Name: fsk_tone_divider

Overview:
Parametrised successor to the single-ratio carrier divider. Generates a 50%-duty square-wave carrier from clk using a small table of programmable half-period values, one per FSK tone. The tone is selected at run time, and changes take effect only at a half-period boundary, so the output stays phase-continuous and glitch-free. Sits between the symbol mapper (drives tone_sel and en) and the ASK/FSK output stage (consumes out and tick).

Parameters:
CNT_W, 9, width of half-period values and of the down-counter
NUM_TONES, 4, number of entries in the tone table (>=2)
SEL_W, $clog2(NUM_TONES), width of tone index signals
DEFAULT_HALF, 256, reset value of every table entry (must be >=1 and < 2**CNT_W)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
en  input  1  run enable; low freezes counter and out
restart  input  1  synchronous phase restart: out low, counter reloaded from tone_sel
tone_sel  input  SEL_W  requested tone; sampled only at boundaries and on restart
cfg_we  input  1  tone table write strobe
cfg_idx  input  SEL_W  table entry to write
cfg_half  input  CNT_W  half-period in clk cycles for that entry
out  output  1  divided carrier
tick  output  1  one-cycle pulse in the cycle in which out toggles
active_tone  output  SEL_W  tone currently being generated
cfg_err  output  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst=0, async):
  - out=0, tick=0, cfg_err=0, active_tone=0.
  - Every table entry = DEFAULT_HALF; cnt = DEFAULT_HALF-1.
- Release is synchronous to clk; the first decrement happens on the first posedge with rst=1 and en=1.
- Counter: cnt counts down each enabled cycle. A boundary is an enabled cycle with cnt==0. At a boundary:
  - out <= ~out; tick <= 1.
  - active_tone <= tone_sel; cnt <= table[tone_sel]-1.
- Period rule: half-period H gives out high for H cycles and low for H cycles (full period 2H). H=1 toggles every cycle (clk/2).
- en=0: cnt, out and active_tone hold; tick=0. On re-enable, counting resumes from the held cnt with no phase loss.
- restart=1 (any en):
  - out <= 0, tick <= 0.
  - active_tone <= tone_sel; cnt <= table[tone_sel]-1.
  - restart has priority over a coincident boundary.
- Tone change mid-half-period: no effect until the next boundary. The current half-period completes with the old length.
- Table write:
  - cfg_we=1 with cfg_half>=1 updates table[cfg_idx] at the clock edge.
  - cfg_half==0 is ignored, and cfg_err pulses for one cycle.
  - cfg_idx >= NUM_TONES is ignored, and cfg_err pulses for one cycle.
- Write/reload collision: a boundary or restart in the same cycle as a write to the same index reloads the OLD value. The new value applies from the following reload.
- The counter running at the time of a write is never modified; only subsequent reloads see the new value.
- Arithmetic: all counter math is unsigned CNT_W bits. With a nonzero table enforced, H-1 never underflows.
- Outputs are registered; no combinational path from inputs to out, tick or cfg_err.
- Controller has two states:
  - RUN (en=1): counting and toggling as above.
  - HOLD (en=0): everything frozen.
  - restart and cfg writes are legal in both states.

Decomposition:
- Shared package fsk_pkg holds:
  - the localparam for the default half-period;
  - a typedef for the tone index;
  - a typedef for the half-period word, used by the symbol mapper as well.
- One sub-module, tone_table: a NUM_TONES x CNT_W register file with write validation and cfg_err generation, plus an async-read port indexed by tone_sel.
- The divider core (counter, toggle, restart priority) stays in fsk_tone_divider.

Test Plan:
- Reset then en=1 with default table (H=256) -> first tick 256 cycles after reset release; out high for 256 cycles, low for 256, repeating; active_tone=0.
- Write idx1=3, idx2=5; tone_sel=1 then restart -> out=0; toggles every 3 cycles (period 6). Switch tone_sel to 2 mid-half-period -> current half finishes at 3, next halves are 5; no short pulse.
- Write idx0=1 and select it -> out toggles every cycle and tick is held high continuously.
- en=0 for 10 cycles when cnt=2 -> out and cnt frozen, tick=0; after en=1, the toggle occurs exactly 3 enabled cycles later.
- Write cfg_half=0 to idx3 -> cfg_err pulses once and table[3] is unchanged (still 256). With NUM_TONES=3, a write to idx3 -> cfg_err pulse.
- restart coincident with a boundary and a write to the selected index (old 4, new 7) -> out=0, no tick, first half-period is 4, following half-periods are 7. Assert rst mid-half-period -> out=0 immediately, without waiting for clk.
